// File: rtl/lfsr_range_rng.sv
// Fibonacci LFSR with seed load and lock-up recovery, plus a req/ack port that
// returns an unbiased index in [0, RANGE-1] by bounded rejection sampling.
//
// state  | meaning
// IDLE   | waiting for req; LFSR steps only with step_en
// SEARCH | evaluating one candidate per cycle; LFSR steps every cycle
// DONE   | result held on value_o/fallback_o until ack
module lfsr_range_rng #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      RANGE      = 6,
  parameter int unsigned      MAX_TRIES  = 4,
  localparam int unsigned     IDX_W      = $clog2(RANGE),
  localparam int unsigned     TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_en_i,
  input  logic             req_i,
  input  logic             ack_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] value_o,
  output logic             fallback_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] state_q_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } fsm_e;

  fsm_e             fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_d;
  logic [WIDTH-1:0] load_d;
  logic [TRY_W-1:0] tries_q;
  logic [IDX_W-1:0] value_q;
  logic             fallback_q;

  logic             fb;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] range_lo;
  logic [IDX_W-1:0] wrap;
  logic             cand_ok;
  logic             last_try;

  // An all-zero state would lock the LFSR, so it restarts from RESET_SEED.
  always_comb begin
    fb = ^(state_q & TAPS);
    if (state_q == '0) begin
      step_d = RESET_SEED;
    end else begin
      step_d = {state_q[WIDTH-2:0], fb};
    end
  end

  assign load_d = (seed_i == '0) ? RESET_SEED : seed_i;

  // cand < 2*RANGE, so subtracting RANGE modulo 2^IDX_W always lands in range.
  assign cand     = state_q[IDX_W-1:0];
  assign cand_ok  = (32'(cand) < RANGE);
  assign range_lo = IDX_W'(RANGE);
  assign wrap     = cand - range_lo;
  assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q      <= S_IDLE;
      state_q    <= RESET_SEED;
      tries_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
    end else if (load_i) begin
      fsm_q      <= S_IDLE;
      state_q    <= load_d;
      tries_q    <= '0;
      fallback_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (step_en_i) begin
            state_q <= step_d;
          end
          if (req_i) begin
            fsm_q   <= S_SEARCH;
            tries_q <= '0;
          end
        end
        S_SEARCH: begin
          state_q <= step_d;
          if (cand_ok) begin
            value_q    <= cand;
            fallback_q <= 1'b0;
            fsm_q      <= S_DONE;
          end else if (last_try) begin
            value_q    <= wrap;
            fallback_q <= 1'b1;
            fsm_q      <= S_DONE;
          end else begin
            tries_q <= tries_q + TRY_W'(1);
          end
        end
        S_DONE: begin
          if (step_en_i) begin
            state_q <= step_d;
          end
          if (ack_i) begin
            fsm_q <= S_IDLE;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign valid_o    = (fsm_q == S_DONE);
  assign busy_o     = (fsm_q == S_SEARCH);
  assign value_o    = value_q;
  assign fallback_o = fallback_q;
  assign state_q_o  = state_q;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Directed bench for lfsr_range_rng: default build (A) plus a MAX_TRIES=2
// build (B) driven with the same stimulus to reach the timeout path.
module tb_lfsr_range_rng;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] seed;
  logic       step_en;
  logic       req;
  logic       ack;

  logic       valid_a, fallback_a, busy_a;
  logic [2:0] value_a;
  logic [3:0] state_a;
  logic       valid_b, fallback_b, busy_b;
  logic [2:0] value_b;
  logic [3:0] state_b;

  int total;
  int bad;

  lfsr_range_rng dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .seed_i     (seed),
    .step_en_i  (step_en),
    .req_i      (req),
    .ack_i      (ack),
    .valid_o    (valid_a),
    .value_o    (value_a),
    .fallback_o (fallback_a),
    .busy_o     (busy_a),
    .state_q_o  (state_a)
  );

  lfsr_range_rng #(.MAX_TRIES(2)) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .seed_i     (seed),
    .step_en_i  (step_en),
    .req_i      (req),
    .ack_i      (ack),
    .valid_o    (valid_b),
    .value_o    (value_b),
    .fallback_o (fallback_b),
    .busy_o     (busy_b),
    .state_q_o  (state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [3:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (state_a !== 4'd1) begin bad++; $display("FAIL reset_state got=%0d exp=1", state_a); end
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_flags got valid=%b busy=%b exp 0 0", valid_a, busy_a);
    end
    total++;
    if (value_a !== 3'd0 || fallback_a !== 1'b0) begin
      bad++; $display("FAIL reset_value got value=%0d fb=%b exp 0 0", value_a, fallback_a);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [16];
    seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
            4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};
    step_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (state_a !== seq[i] || state_a === 4'd0) begin
        bad++; $display("FAIL sequence[%0d] got=%0d exp=%0d", i, state_a, seq[i]);
      end
      if (i < 15) tick();
    end
    step_en = 1'b0;
  endtask

  // Load a seed, request, and wait (bounded) for valid on the chosen build.
  task automatic run_req(input logic [3:0] s, input bit use_b, input logic [2:0] exp_val,
                         input logic exp_fb, input int exp_lat, input string name);
    int lat;
    load_seed(s);
    total++;
    if (state_a !== s) begin bad++; $display("FAIL %s_load got=%0d exp=%0d", name, state_a, s); end
    req = 1'b1;
    tick();
    req = 1'b0;
    total++;
    if ((use_b ? busy_b : busy_a) !== 1'b1 || (use_b ? valid_b : valid_a) !== 1'b0) begin
      bad++; $display("FAIL %s_busy got busy=%b valid=%b exp 1 0", name,
                      use_b ? busy_b : busy_a, use_b ? valid_b : valid_a);
    end
    lat = 0;
    while ((use_b ? valid_b : valid_a) !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    total++;
    if ((use_b ? value_b : value_a) !== exp_val || (use_b ? fallback_b : fallback_a) !== exp_fb) begin
      bad++; $display("FAIL %s_result got value=%0d fb=%b exp value=%0d fb=%b", name,
                      use_b ? value_b : value_a, use_b ? fallback_b : fallback_a, exp_val, exp_fb);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++;
    if ((use_b ? valid_b : valid_a) !== 1'b0) begin
      bad++; $display("FAIL %s_ack got valid=%b exp 0", name, use_b ? valid_b : valid_a);
    end
  endtask

  task automatic test_immediate();
    run_req(4'd1, 1'b0, 3'd1, 1'b0, 1, "immediate");
    total++;
    if (state_a !== 4'd2) begin bad++; $display("FAIL immediate_state got=%0d exp=2", state_a); end
  endtask

  task automatic test_rejection();
    run_req(4'd6, 1'b0, 3'd5, 1'b0, 2, "reject6");
    total++;
    if (state_a !== 4'd10) begin bad++; $display("FAIL reject6_state got=%0d exp=10", state_a); end
    run_req(4'd15, 1'b0, 3'd4, 1'b0, 3, "reject15");
  endtask

  task automatic test_timeout();
    run_req(4'd15, 1'b1, 3'd0, 1'b1, 2, "timeout");
  endtask

  task automatic test_zero_abort();
    load_seed(4'd0);
    total++;
    if (state_a !== 4'd1) begin bad++; $display("FAIL zero_seed got=%0d exp=1", state_a); end
    req = 1'b1;
    tick();
    req = 1'b0;
    load_seed(4'd9);
    total++;
    if (state_a !== 4'd9 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL abort_search got state=%0d valid=%b busy=%b exp 9 0 0", state_a, valid_a, busy_a);
    end
    load_seed(4'd1);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    total++;
    if (valid_a !== 1'b1) begin bad++; $display("FAIL abort_reach_done got valid=%b exp 1", valid_a); end
    load_seed(4'd9);
    tick();
    total++;
    if (state_a !== 4'd9 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL abort_done got state=%0d valid=%b busy=%b exp 9 0 0", state_a, valid_a, busy_a);
    end
  endtask

  task automatic test_async_reset();
    load_seed(4'd15);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    total++;
    if (valid_a !== 1'b1 || value_a !== 3'd4 || state_a !== 4'd8 || valid_b !== 1'b1 || fallback_b !== 1'b1) begin
      bad++; $display("FAIL areset_pre got a:valid=%b value=%0d state=%0d b:valid=%b fb=%b exp 1 4 8 1 1",
                      valid_a, value_a, state_a, valid_b, fallback_b);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (valid_a !== 1'b0 || value_a !== 3'd0 || fallback_a !== 1'b0 || state_a !== 4'd1) begin
      bad++; $display("FAIL areset_a got valid=%b value=%0d fb=%b state=%0d exp 0 0 0 1",
                      valid_a, value_a, fallback_a, state_a);
    end
    total++;
    if (valid_b !== 1'b0 || fallback_b !== 1'b0 || state_b !== 4'd1) begin
      bad++; $display("FAIL areset_b got valid=%b fb=%b state=%0d exp 0 0 1", valid_b, fallback_b, state_b);
    end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    load_seed(4'd1);
    req = 1'b1;
    tick();
    tick();
    total++;
    if (valid_a !== 1'b1 || value_a !== 3'd1) begin
      bad++; $display("FAIL b2b_first got valid=%b value=%0d exp 1 1", valid_a, value_a);
    end
    ack = 1'b1;
    tick();
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_ack got valid=%b busy=%b exp 0 0", valid_a, busy_a);
    end
    ack = 1'b0;
    tick();
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_rereq got busy=%b exp 1", busy_a); end
    req = 1'b0;
    tick();
    total++;
    if (valid_a !== 1'b1 || value_a !== 3'd2) begin
      bad++; $display("FAIL b2b_second got valid=%b value=%0d exp 1 2", valid_a, value_a);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (2) tick();
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got valid=%b busy=%b exp 0 0", valid_a, busy_a);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    load    = 1'b0;
    seed    = 4'd0;
    step_en = 1'b0;
    req     = 1'b0;
    ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sequence();
    test_immediate();
    test_rejection();
    test_timeout();
    test_zero_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_range_rng.md
# lfsr_range_rng

Parametrised pseudo-random source for the game logic: a WIDTH-bit Fibonacci LFSR with programmable taps, seed loading, all-zero lock-up recovery and free-run stepping. It adds a request/acknowledge port that returns an unbiased index in [0, RANGE-1] by rejection sampling, with a bounded retry count. The index feeds mole-position and timing selection; the raw state stays visible for debug and display.

## Interface
- WIDTH, 4: LFSR state width, >= 2.
- TAPS, 4'b1100: feedback mask; bit i set means state[i] is included in the XOR feedback.
- RESET_SEED, 1: state after reset, and substitute value for any all-zero seed or state. Must be nonzero.
- RANGE, 6: number of output values, 2..2^WIDTH. IDX_W = clog2(RANGE), which must be <= WIDTH.
- MAX_TRIES, 4: maximum candidate evaluations per request, >= 1.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- load  in  1  load seed into the state on the next edge.
- seed  in  WIDTH  seed value.
- step_en  in  1  free-run advance while IDLE or DONE.
- req  in  1  request one index; sampled only in IDLE.
- ack  in  1  consume the result; sampled only in DONE.
- valid  out  1  value is held and valid; asserted in DONE.
- value  out  IDX_W  result index, always < RANGE when valid.
- fallback  out  1  value came from the timeout path; qualified by valid.
- busy  out  1  high in SEARCH.
- state_q  out  WIDTH  current LFSR state.

## Operation
- Feedback and stepping:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}.
  - If state == 0, next = RESET_SEED. This is lock-up recovery.
- Priority order: rst > load > FSM.
- load:
  - state <= (seed == 0) ? RESET_SEED : seed.
  - FSM goes to IDLE; valid and fallback go to 0; tries goes to 0.
  - This applies in any FSM state and aborts a pending request or result.
- FSM states are IDLE, SEARCH and DONE.
- IDLE:
  - State steps iff step_en.
  - req = 1 moves to SEARCH with tries = 0.
- SEARCH:
  - State steps every cycle, regardless of step_en.
  - cand = state[IDX_W-1:0], taken from the current (pre-step) state.
  - If cand < RANGE: value <= cand, fallback <= 0, move to DONE.
  - Else, if tries == MAX_TRIES-1: value <= cand - RANGE, fallback <= 1, move to DONE. This is always < RANGE because cand < 2·RANGE.
  - Else: tries <= tries + 1, stay in SEARCH.
- DONE:
  - valid = 1; value and fallback are held stable.
  - State steps iff step_en.
  - ack = 1 moves to IDLE. A req in the same cycle is ignored.
- req outside IDLE is ignored. ack outside DONE is ignored.
- Width rules:
  - The tries counter is clog2(MAX_TRIES+1) bits.
  - Comparisons are unsigned; the subtraction is done at IDX_W bits.

## Timing
- Reset values:
  - state_q = RESET_SEED.
  - FSM = IDLE; tries = 0.
  - valid = 0, value = 0, fallback = 0, busy = 0.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Load latency: seed appears on state_q one edge after load is sampled.
- Request latency: req is sampled at edge k, and busy is high from k.
  - Acceptance at the n-th evaluation gives valid = 1 after edge k+n, so minimum latency is 1.
  - Maximum is k+MAX_TRIES.
- ack sampled at edge m gives valid = 0 after m. A new req is accepted at m+1 at the earliest.
- Reset asserted mid-SEARCH or in DONE: outputs drop to reset values immediately (asynchronously), and the state returns to RESET_SEED.

## Test plan
All scenarios use the defaults: WIDTH=4, TAPS=4'b1100, RESET_SEED=1, RANGE=6, MAX_TRIES=4.

- **Sequence and period:** reset, then step_en held high for 16 cycles -> state_q runs 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,1 (period 15); it is never 0.
- **Immediate accept:** load seed 1, then req -> valid after 1 edge with value=1 and fallback=0; ack -> valid=0 and state_q=2.
- **Rejection:**
  - Load seed 6, then req -> candidate 6 is rejected, then 13 gives candidate 5 -> valid after 2 edges with value=5.
  - Load seed 15, then req -> candidates 7 and 6 are rejected, then 12 gives candidate 4 -> value=4, latency 3.
- **Timeout:** rebuild with MAX_TRIES=2; load 15, then req -> candidates 7 and 6 are rejected -> value=0, fallback=1, latency 2.
- **Zero seed and abort:** load seed 0 -> state_q=1. Issue req, then assert load with seed 9 while in SEARCH or DONE -> FSM returns to IDLE, valid=0, state_q=9.
- **Async reset and ignored inputs:**
  - Pulse rst between clock edges during DONE -> valid, value and fallback go to 0 and state_q goes to 1 before the next edge.
  - req held high through DONE together with ack -> exactly one result is produced per IDLE-sampled req.
